game_input_ctrl: RTL and testbench

- Conditions the raw board buttons (btnL, btnR, btnU) and the start switch into clean, tick-aligned game commands for the game-state logic that drives the VGA display.
- Sits directly upstream of that logic and replaces its direct button sampling and DIV_CLK-derived update clock.
- Generates one game_tick enable pulse per update period, plus movement levels and a handshaked one-shot fire request.

---
 rtl/game_input_pkg.sv | 22 ++
 rtl/game_input_ctrl_btn_debounce.sv | 54 +++++
 rtl/game_input_ctrl.sv | 162 ++++++++++++++++
 tb/tb_game_input_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_input_pkg.sv
// Shared types and default timing for the game input conditioning block.
package game_input_pkg;

  // Fire request state machine encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    REQ   = 2'b10,
    HOLD  = 2'b11
  } fire_state_e;

  // Bit positions of each button inside btn_db.
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;

  // Default timing for a 50 MHz board clock.
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_TICK_CYCLES     = 2097152;
  localparam int DEF_CNT_W           = 22;

endpackage

// File: rtl/game_input_ctrl_btn_debounce.sv
// Two-flop synchroniser followed by a stability counter for one raw button.
module btn_debounce
  import game_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_db
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive cycles the synchronised input disagrees with the debounced value.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == DB_LAST) begin
      db_d  = sync2_q;
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign btn_db = db_q;

endmodule

// File: rtl/game_input_ctrl.sv
// Turns raw buttons into debounced levels, tick-aligned move commands and a
// handshaked one-shot fire request for the game-state logic.
module game_input_ctrl
  import game_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TICK_CYCLES     = DEF_TICK_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnU,
  input  logic       shoot_ack,
  output logic       game_tick,
  output logic       move_left,
  output logic       move_right,
  output logic       shoot_req,
  output logic [2:0] btn_db
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [2:0]       btn_raw_s;
  logic [2:0]       btn_db_s;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_s;
  logic             move_left_q, move_left_d;
  logic             move_right_q, move_right_d;
  logic             shoot_req_q, shoot_req_d;
  logic             u_prev_q, u_prev_d;
  logic             u_rise_s;
  fire_state_e      state_q, state_d;

  assign btn_raw_s = {btnU, btnR, btnL};

  for (genvar i = 0; i < 3; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_btn_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_raw_s[i]),
      .btn_db  (btn_db_s[i])
    );
  end

  // All top-level state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt_q   <= {CNT_W{1'b0}};
      move_left_q  <= 1'b0;
      move_right_q <= 1'b0;
      shoot_req_q  <= 1'b0;
      u_prev_q     <= 1'b0;
      state_q      <= IDLE;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      move_left_q  <= move_left_d;
      move_right_q <= move_right_d;
      shoot_req_q  <= shoot_req_d;
      u_prev_q     <= u_prev_d;
      state_q      <= state_d;
    end
  end

  // Update-period counter; the tick is decoded from the terminal count while running.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick_s     = 1'b0;
    if (!enable) begin
      tick_cnt_d = {CNT_W{1'b0}};
    end else if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = {CNT_W{1'b0}};
      tick_s     = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end
  end

  // Movement levels sampled on ticks only; opposing or fire presses cancel movement.
  always_comb begin
    move_left_d  = move_left_q;
    move_right_d = move_right_q;
    if (!enable) begin
      move_left_d  = 1'b0;
      move_right_d = 1'b0;
    end else if (tick_s) begin
      move_left_d  = btn_db_s[BTN_L] & ~btn_db_s[BTN_R] & ~btn_db_s[BTN_U];
      move_right_d = btn_db_s[BTN_R] & ~btn_db_s[BTN_L] & ~btn_db_s[BTN_U];
    end else begin
      move_left_d  = move_left_q;
      move_right_d = move_right_q;
    end
  end

  assign u_rise_s = btn_db_s[BTN_U] & ~u_prev_q;

  // Fire FSM: one request per press, raised on a tick and held until acknowledged.
  always_comb begin
    state_d     = state_q;
    shoot_req_d = shoot_req_q;
    u_prev_d    = btn_db_s[BTN_U];
    if (!enable) begin
      state_d     = IDLE;
      shoot_req_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (u_rise_s) begin
            // A fire press while steering is swallowed but must still be released.
            if (btn_db_s[BTN_L] || btn_db_s[BTN_R]) begin
              state_d = HOLD;
            end else begin
              state_d = ARMED;
            end
          end else begin
            state_d = IDLE;
          end
        end
        ARMED: begin
          if (tick_s) begin
            shoot_req_d = 1'b1;
            state_d     = REQ;
          end else begin
            state_d = ARMED;
          end
        end
        REQ: begin
          // Ack only counts once the request is already visible.
          if (shoot_req_q && shoot_ack) begin
            shoot_req_d = 1'b0;
            state_d     = HOLD;
          end else begin
            state_d = REQ;
          end
        end
        HOLD: begin
          if (!btn_db_s[BTN_U]) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d     = IDLE;
          shoot_req_d = 1'b0;
        end
      endcase
    end
  end

  assign game_tick  = tick_s;
  assign move_left  = move_left_q;
  assign move_right = move_right_q;
  assign shoot_req  = shoot_req_q;
  assign btn_db     = btn_db_s;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed self-checking bench for game_input_ctrl with short timing constants.
module tb_game_input_ctrl;
  import game_input_pkg::*;

  localparam int DB_C   = 4;
  localparam int TICK_C = 8;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       btnL, btnR, btnU;
  logic       shoot_ack;
  logic       game_tick;
  logic       move_left, move_right;
  logic       shoot_req;
  logic [2:0] btn_db;

  int checks_done = 0;
  int checks_failed = 0;
  int n;

  game_input_ctrl #(
    .DEBOUNCE_CYCLES (DB_C),
    .TICK_CYCLES     (TICK_C),
    .CNT_W           (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .btnL       (btnL),
    .btnR       (btnR),
    .btnU       (btnU),
    .shoot_ack  (shoot_ack),
    .game_tick  (game_tick),
    .move_left  (move_left),
    .move_right (move_right),
    .shoot_req  (shoot_req),
    .btn_db     (btn_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_done++;
    if (obs !== exp) begin
      checks_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // Returns the number of edges until game_tick is seen high (bounded).
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (game_tick !== 1'b1 && cnt < 40);
    if (game_tick !== 1'b1) check_eq("tick_timeout", 32'(game_tick), 32'd1);
  endtask

  // Returns the number of edges until btn_db[idx] equals val (bounded).
  task automatic wait_db(input int idx, input logic val, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (btn_db[idx] !== val && cnt < 30);
  endtask

  // Watches a number of ticks and records whether shoot_req was ever seen.
  task automatic watch_no_req(input string tag, input int ticks);
    logic seen = 1'b0;
    int   t = 0;
    int   cyc = 0;
    while (t < ticks && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (shoot_req) seen = 1'b1;
      if (game_tick) t++;
    end
    @(negedge clk);
    if (shoot_req) seen = 1'b1;
    check_eq({tag, "_ticks"}, 32'(t), 32'(ticks));
    check_eq({tag, "_no_req"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic seen;
    reset_n = 1'b0; enable = 1'b1; shoot_ack = 1'b0;
    btnL = 1'b1; btnR = 1'b1; btnU = 1'b1;

    // 1. Reset with buttons pressed, then tick period.
    step(3);
    check_eq("rst_tick", 32'(game_tick), 32'd0);
    check_eq("rst_ml", 32'(move_left), 32'd0);
    check_eq("rst_mr", 32'(move_right), 32'd0);
    check_eq("rst_req", 32'(shoot_req), 32'd0);
    check_eq("rst_db", 32'(btn_db), 32'd0);
    btnL = 1'b0; btnR = 1'b0; btnU = 1'b0;
    reset_n = 1'b1;
    // Counter spends one cycle on each of 0..7: the tick is the 8th enabled cycle, 7 edges on.
    wait_tick(n);
    check_eq("first_tick", 32'(n), 32'(TICK_C - 1));
    wait_tick(n);
    check_eq("tick_period", 32'(n), 32'(TICK_C));

    // 2. Debounce: a 3-cycle glitch is rejected, a clean edge lands after D+2 edges.
    btnL = 1'b1; step(3); btnL = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (btn_db[BTN_L]) seen = 1'b1;
    end
    check_eq("glitch_L", 32'(seen), 32'd0);
    wait_tick(n);
    btnR = 1'b1;
    wait_db(BTN_R, 1'b1, n);
    check_eq("db_latency_R", 32'(n), 32'(DB_C + 2));

    // 3. Movement registered on ticks.
    wait_tick(n);
    check_eq("tick_after_R", 32'(n), 32'd2);
    check_eq("mr_at_tick", 32'(move_right), 32'd0);
    step(1);
    check_eq("mr_after_tick", 32'(move_right), 32'd1);
    check_eq("ml_after_tick", 32'(move_left), 32'd0);
    step(6);
    check_eq("no_tick_mid", 32'(game_tick), 32'd0);
    check_eq("mr_held", 32'(move_right), 32'd1);
    step(1);
    check_eq("tick_again", 32'(game_tick), 32'd1);
    btnL = 1'b1;
    wait_tick(n);
    check_eq("tick_LR", 32'(n), 32'(TICK_C));
    step(1);
    check_eq("both_mr", 32'(move_right), 32'd0);
    check_eq("both_ml", 32'(move_left), 32'd0);
    check_eq("db_LR", 32'(btn_db), 32'h3);
    btnR = 1'b0;
    wait_tick(n);
    check_eq("tick_Lonly", 32'(n), 32'd7);
    step(1);
    check_eq("ml_only", 32'(move_left), 32'd1);
    check_eq("mr_off", 32'(move_right), 32'd0);
    btnL = 1'b0; step(8);

    // 4. Fire handshake and one shot per press.
    wait_tick(n);
    btnU = 1'b1;
    wait_db(BTN_U, 1'b1, n);
    check_eq("db_latency_U", 32'(n), 32'(DB_C + 2));
    wait_tick(n);
    check_eq("req_before_tick", 32'(shoot_req), 32'd0);
    step(1);
    check_eq("req_rise", 32'(shoot_req), 32'd1);
    step(10);
    check_eq("req_held", 32'(shoot_req), 32'd1);
    shoot_ack = 1'b1; step(1); shoot_ack = 1'b0;
    check_eq("req_drop", 32'(shoot_req), 32'd0);
    watch_no_req("hold_U", 3);
    btnU = 1'b0; step(8);
    wait_tick(n);
    btnU = 1'b1;
    wait_tick(n);
    check_eq("req2_pre", 32'(shoot_req), 32'd0);
    step(1);
    check_eq("req2_rise", 32'(shoot_req), 32'd1);
    shoot_ack = 1'b1; step(1); shoot_ack = 1'b0;
    check_eq("req2_drop", 32'(shoot_req), 32'd0);
    btnU = 1'b0; step(8);
    // Fire press while steering is swallowed even after steering stops.
    btnR = 1'b1; step(8);
    wait_tick(n);
    btnU = 1'b1; step(8);
    btnR = 1'b0;
    watch_no_req("steer_U", 3);
    btnU = 1'b0; step(8);

    // 5. U edge coincides with tick: fire one period later; ack on REQ entry ignored.
    wait_tick(n);
    step(2);
    btnU = 1'b1;
    step(6);
    check_eq("sim_db_U", 32'(btn_db[BTN_U]), 32'd1);
    check_eq("sim_tick", 32'(game_tick), 32'd1);
    step(1);
    check_eq("sim_no_req", 32'(shoot_req), 32'd0);
    step(7);
    check_eq("sim_tick2", 32'(game_tick), 32'd1);
    check_eq("sim_req_pre", 32'(shoot_req), 32'd0);
    shoot_ack = 1'b1; step(1); shoot_ack = 1'b0;
    check_eq("sim_req_rise", 32'(shoot_req), 32'd1);
    step(1);
    check_eq("early_ack_ignored", 32'(shoot_req), 32'd1);

    // 6. Abort by enable drop, then by reset.
    enable = 1'b0; step(1);
    check_eq("dis_req", 32'(shoot_req), 32'd0);
    check_eq("dis_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("dis_mr", 32'(move_right), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (game_tick) seen = 1'b1;
    end
    check_eq("dis_no_tick", 32'(seen), 32'd0);
    enable = 1'b1; btnU = 1'b0; step(8);
    wait_tick(n);
    btnU = 1'b1;
    wait_tick(n);
    step(1);
    check_eq("abort_req_up", 32'(shoot_req), 32'd1);
    reset_n = 1'b0; btnU = 1'b0; step(1);
    check_eq("rst_abort_req", 32'(shoot_req), 32'd0);
    check_eq("rst_abort_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("rst_abort_db", 32'(btn_db), 32'd0);
    check_eq("rst_abort_tick", 32'(game_tick), 32'd0);
    step(2);
    reset_n = 1'b1;
    step(12);
    check_eq("post_rst_req", 32'(shoot_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
    $finish;
  end

endmodule
